pwm_dac: RTL and testbench
==========================

PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 Parameter: PRESCALE, default 1, clock cycles per PWM tick; legal range 1..256.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 holdn  in  1  low freezes all internal state and outputs.
REQ-006 sample  in  8  unsigned duty sample, e.g. from the triangle generator output.
REQ-007 sample_valid  in  1  sample is presented.
REQ-008 sample_ready  out  1  one-entry buffer can accept a sample.
REQ-009 pwm  out  1  registered PWM output.
REQ-010 period_start  out  1  one-cycle period strobe; the port exists only with PWM_PERIOD_STROBE_EN.

Function
REQ-011 Prescaler: counts 0..PRESCALE-1 while holdn=1; tick asserts in the cycle the count equals PRESCALE-1, then the count wraps to 0; PRESCALE=1 gives a tick every cycle.
REQ-012 Phase counter pcnt: 8-bit; increments on tick; wraps 255->0; one PWM period = 256 ticks = 256*PRESCALE clocks.
REQ-013 Boundary: a tick with pcnt=255.
REQ-014 Buffer state machine, states EMPTY and FULL:
- EMPTY->FULL on accept (sample_valid & sample_ready).
- FULL->EMPTY at a boundary, loading the buffer into duty.
REQ-015 sample_ready = (state==EMPTY) & holdn & ~reset (combinational).
REQ-016 Accept coinciding with a boundary while EMPTY: the sample is stored in the buffer; it takes effect at the following boundary, with no bypass.
REQ-017 With no new sample at a boundary, duty keeps its value.
REQ-018 pwm <= (pcnt < duty) each clock while holdn=1, giving one cycle latency from pcnt to pwm.
- duty=0x00: pwm constantly 0.
- duty=0xFF: pwm low for exactly 1 tick per period.
REQ-019 holdn=0:
- Prescaler, pcnt, duty, buffer and pwm are all frozen.
- No accept occurs.
- Period is stretched by the number of held cycles.

Reset
REQ-020 While reset=1: prescaler=0, pcnt=0, duty=0x00, buffer EMPTY, pwm=0, period_start=0, sample_ready=0.
REQ-021 Reset asserted mid-period discards the buffer and duty; pwm is 0 on the cycle after the reset edge.
REQ-022 Reset has priority over holdn.

Configuration
REQ-023 Macro PWM_PERIOD_STROBE_EN defined:
- Port period_start exists.
- It is registered and pulses high for one clock in the same cycle pwm first reflects pcnt=0 of a new period.
REQ-024 PWM_PERIOD_STROBE_EN undefined: the port and its logic are absent; all other behaviour is identical.

Structure
REQ-025 Shared package pwm_pkg holds PWM_WIDTH=8, the buffer-state enum type (EMPTY, FULL) and the PRESCALE maximum constant.
REQ-026 The prescaler is one sub-module, tick_gen, with inputs clock, reset and holdn, output tick, and parameter PRESCALE.

Verification
REQ-027 The bench covers these directed scenarios, all with PRESCALE=1 unless stated:
- After reset, sample 0x80 accepted in the first cycle -> duty loads at the first boundary; each subsequent period has pwm high 128 clocks then low 128.
- duty 0x00 -> pwm stays 0 for 3 periods; duty 0xFF -> pwm low exactly 1 clock per period.
- Samples 0x10 then 0x20 presented back-to-back -> 0x20 is stalled (sample_ready=0) until the boundary; 0x10 is applied first, 0x20 one period later.
- holdn low for 10 clocks at pcnt=50 -> pwm and pcnt are frozen, and that period lasts 266 clocks.
- PRESCALE=4, duty 0x40 -> period 1024 clocks with pwm high 256 clocks; period_start (macro on) pulses every 1024 clocks.
- Reset at pcnt=100 with duty 0xC0 and a FULL buffer -> pwm=0 the next cycle; after release pwm stays 0 until a new sample is loaded.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM DAC: datapath width, prescaler limit and
// the one-entry sample buffer state type.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH    = 8;
  localparam int unsigned PRESCALE_MAX = 256;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/pwm_dac_tick_gen.sv
// Prescaler for the PWM DAC: emits a one-clock tick every PRESCALE active
// (holdn=1) clocks; the count freezes while holdn is low.
module tick_gen
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic holdn,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  if (PRESCALE < 1 || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("tick_gen: PRESCALE out of range 1..256");
  end

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (holdn) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = holdn & ~reset & w_wrap;

endmodule

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC with a one-entry sample buffer loaded into duty at period
// boundaries. Optional period_start strobe is enabled by PWM_PERIOD_STROBE_EN.
module pwm_dac
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 holdn,
  input  logic [PWM_WIDTH-1:0] sample,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 pwm
`ifdef PWM_PERIOD_STROBE_EN
  ,
  output logic                 period_start
`endif
);

  buf_state_t           r_state;
  buf_state_t           w_state_next;
  logic                 w_tick;
  logic                 w_boundary;
  logic                 w_accept;
  logic                 w_load;
  logic [PWM_WIDTH-1:0] r_pcnt;
  logic [PWM_WIDTH-1:0] r_duty;
  logic [PWM_WIDTH-1:0] r_buf;
  logic                 r_pwm;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .holdn (holdn),
    .tick  (w_tick)
  );

  assign w_boundary   = w_tick & (r_pcnt == '1);
  assign sample_ready = (r_state == EMPTY) & holdn & ~reset;
  assign w_accept     = sample_valid & sample_ready;

  // A sample accepted on a boundary while EMPTY only fills the buffer; it
  // reaches duty at the next boundary.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    if (r_state == EMPTY) begin
      if (w_accept) w_state_next = FULL;
    end else begin
      if (w_boundary) begin
        w_state_next = EMPTY;
        w_load       = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pcnt <= '0;
      r_duty <= '0;
      r_buf  <= '0;
      r_pwm  <= 1'b0;
    end else if (holdn) begin
      if (w_tick)   r_pcnt <= r_pcnt + PWM_WIDTH'(1);
      if (w_accept) r_buf  <= sample;
      if (w_load)   r_duty <= r_buf;
      r_pwm <= (r_pcnt < r_duty);
    end
  end

  assign pwm = r_pwm;

`ifdef PWM_PERIOD_STROBE_EN
  logic r_first0;
  logic r_period_start;

  // Delayed by one extra stage so the strobe lines up with pwm showing pcnt=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_first0       <= 1'b0;
      r_period_start <= 1'b0;
    end else if (holdn) begin
      r_first0       <= w_boundary;
      r_period_start <= r_first0;
    end
  end

  assign period_start = r_period_start;
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: PRESCALE=1 and PRESCALE=4 instances driven
// in lock step and checked every cycle against an arithmetic reference model.
module tb_pwm_dac;

  logic       clock = 1'b0;
  logic       reset, holdn, sample_valid;
  logic [7:0] sample;
  logic [1:0] rdy, pw, ps;

  always #5 clock = ~clock;

  pwm_dac #(.PRESCALE(1)) dut1 (
    .clock(clock), .reset(reset), .holdn(holdn), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(rdy[0]), .pwm(pw[0])
`ifdef PWM_PERIOD_STROBE_EN
    , .period_start(ps[0])
`endif
  );

  pwm_dac #(.PRESCALE(4)) dut4 (
    .clock(clock), .reset(reset), .holdn(holdn), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(rdy[1]), .pwm(pw[1])
`ifdef PWM_PERIOD_STROBE_EN
    , .period_start(ps[1])
`endif
  );

`ifndef PWM_PERIOD_STROBE_EN
  assign ps = '0;
`endif

  // Reference model: m_act counts active clocks since reset; pcnt and the
  // period boundary follow from it by division and modulo.
  int          m_act  [2];
  logic [7:0]  m_duty [2];
  logic [7:0]  m_buf  [2];
  logic        m_full [2];
  logic        m_pwm  [2];
  logic        m_ps   [2];
  int          m_pre  [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] d_r, d_p, d_s;

  typedef struct {
    logic [7:0] smp;
    int         exp_hi;
    int         exp_ps1;
    int         exp_ps4;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void mstep(input int k, input logic rst, input logic hn,
                                input logic acc, input logic [7:0] s);
    int per;
    int pcnt;
    per = 256 * m_pre[k];
    if (rst) begin
      m_act[k]  = 0;
      m_duty[k] = 8'h00;
      m_full[k] = 1'b0;
      m_pwm[k]  = 1'b0;
      m_ps[k]   = 1'b0;
    end else if (hn) begin
      pcnt     = (m_act[k] / m_pre[k]) % 256;
      m_pwm[k] = (pcnt < int'(m_duty[k]));
      m_ps[k]  = (m_act[k] % per == 0) && (m_act[k] != 0);
      if ((m_act[k] % per == per - 1) && m_full[k]) begin
        m_duty[k] = m_buf[k];
        m_full[k] = 1'b0;
      end
      if (acc) begin
        m_buf[k]  = s;
        m_full[k] = 1'b1;
      end
      m_act[k]++;
    end
  endfunction

  task automatic cyc(input logic rst, input logic hn, input logic v, input logic [7:0] s,
                     output logic [1:0] o_rdy, output logic [1:0] o_pw, output logic [1:0] o_ps);
    logic [1:0] acc;
    reset = rst; holdn = hn; sample_valid = v; sample = s;
    #1;
    o_rdy = rdy;
    for (int k = 0; k < 2; k++) begin
      logic er;
      er = !m_full[k] && hn && !rst;
      chk($sformatf("sample_ready[%0d]", k), 32'(rdy[k]), 32'(er));
      acc[k] = v && er;
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) mstep(k, rst, hn, acc[k], s);
    @(negedge clock);
    o_pw = pw;
    o_ps = ps;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pwm[%0d]", k), 32'(pw[k]), 32'(m_pwm[k]));
`ifdef PWM_PERIOD_STROBE_EN
      chk($sformatf("period_start[%0d]", k), 32'(ps[k]), 32'(m_ps[k]));
`endif
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b0, 8'h00, d_r, d_p, d_s);
  endtask

  task automatic do_reset();
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 8'h00, d_r, d_p, d_s);
  endtask

  task automatic count_hi(input int n, output int h1, output int h4, output int q1, output int q4);
    logic [1:0] r, p, s;
    h1 = 0; h4 = 0; q1 = 0; q4 = 0;
    repeat (n) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, r, p, s);
      h1 += int'(p[0]); h4 += int'(p[1]);
      q1 += int'(s[0]); q4 += int'(s[1]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] r, p, s;
    int h1, h4, q1, q4, stall, len, found;
    logic got, held, prev, frozen;

    m_pre[0] = 1; m_pre[1] = 4;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_duty[k] = '0; m_buf[k] = '0;
      m_full[k] = 1'b0; m_pwm[k] = 1'b0; m_ps[k] = 1'b0;
    end
    reset = 1'b1; holdn = 1'b1; sample_valid = 1'b0; sample = '0;
    tbl[0] = '{8'h00, 0,    4, 1};
    tbl[1] = '{8'h01, 4,    4, 1};
    tbl[2] = '{8'h40, 256,  4, 1};
    tbl[3] = '{8'h80, 512,  4, 1};
    tbl[4] = '{8'hFF, 1020, 4, 1};

    @(negedge clock);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 8'h55, r, p, s);
    chk("reset_pwm", 32'(p), 32'(0));
    chk("reset_ready", 32'(r), 32'(0));

    // Duty table: 1024-clock window = 4 periods (PRESCALE=1) or 1 period (PRESCALE=4).
    for (int i = 0; i < 5; i++) begin
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, tbl[i].smp, r, p, s);
      chk("first_accept", 32'(r), 32'(2'b11));
      run(1030);
      count_hi(1024, h1, h4, q1, q4);
      chk($sformatf("hi1_duty%0h", tbl[i].smp), h1, tbl[i].exp_hi);
      chk($sformatf("hi4_duty%0h", tbl[i].smp), h4, tbl[i].exp_hi);
`ifdef PWM_PERIOD_STROBE_EN
      chk("ps_count1", q1, tbl[i].exp_ps1);
      chk("ps_count4", q4, tbl[i].exp_ps4);
`endif
    end

    // Back-to-back samples: second one stalls until the first boundary.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 8'h10, r, p, s);
    stall = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'h20, r, p, s);
      if (r[0]) got = 1'b1;
      else      stall++;
    end
    chk("b2b_stall", stall, 255);
    count_hi(256, h1, h4, q1, q4);
    chk("b2b_first", h1, 16);
    count_hi(256, h1, h4, q1, q4);
    chk("b2b_second", h1, 32);

    // holdn low 10 clocks at pcnt=50 stretches that period to 266 clocks.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 8'h80, r, p, s);
    run(300);
    prev = pw[0]; found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, r, p, s);
      if (!prev && p[0]) found = 1;
      prev = p[0];
    end
    chk("hold_sync", found, 1);
    len = 0; held = 1'b0; found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      if (!held && (m_act[0] % 256 == 50)) begin
        frozen = pw[0];
        repeat (10) begin
          cyc(1'b0, 1'b0, 1'b1, 8'hAA, r, p, s);
          chk("hold_frozen", 32'(p[0]), 32'(frozen));
        end
        len += 10; held = 1'b1;
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00, r, p, s);
      len++;
      if (!prev && p[0]) found = 1;
      prev = p[0];
    end
    chk("hold_period", len, 266);

    // PRESCALE=4 period length measured on dut4.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 8'h40, r, p, s);
    run(1100);
    prev = pw[1]; found = 0;
    for (int i = 0; i < 1100 && found == 0; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, r, p, s);
      if (!prev && p[1]) found = 1;
      prev = p[1];
    end
    chk("p4_sync", found, 1);
    len = 0; h4 = 0; q4 = 0; found = 0;
    for (int i = 0; i < 1200 && found == 0; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, r, p, s);
      len++;
      if (!prev && p[1]) found = 1;
      else begin h4 += int'(p[1]); q4 += int'(s[1]); end
      prev = p[1];
    end
    chk("p4_period", len, 1024);
    chk("p4_high", h4 + 1, 256);
`ifdef PWM_PERIOD_STROBE_EN
    chk("p4_ps_pulses", q4 + int'(s[1]), 1);
`endif

    // Reset mid-period with duty 0xC0 and a FULL buffer.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 8'hC0, r, p, s);
    run(300);
    cyc(1'b0, 1'b1, 1'b1, 8'h33, r, p, s);
    for (int i = 0; i < 300 && (m_act[0] % 256 != 100); i++) run(1);
    chk("rst_pre_pwm", 32'(pw[0]), 32'(1));
    cyc(1'b1, 1'b1, 1'b0, 8'h00, r, p, s);
    chk("rst_pwm", 32'(p[0]), 32'(0));
    cyc(1'b0, 1'b1, 1'b0, 8'h00, r, p, s);
    chk("rst_ready", 32'(r[0]), 32'(1));
    count_hi(600, h1, h4, q1, q4);
    chk("rst_idle_hi1", h1, 0);
    chk("rst_idle_hi4", h4, 0);

    // Randomised traffic against the model.
    do_reset();
    repeat (3000) begin
      cyc(($urandom % 400) == 0, ($urandom % 8) != 0, ($urandom % 3) == 0,
          8'($urandom), r, p, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
